// File: rtl/rect_motion_ctl_if.sv
// rect_motion_ctl_if: pointer/blank inputs and rectangle position outputs of rect_motion_ctl.
interface rect_motion_ctl_if;
    logic        vblnk_in;
    logic        mouse_left;
    logic [11:0] mouse_xpos;
    logic [11:0] mouse_ypos;
    logic [11:0] xpos;
    logic [11:0] ypos;
    logic        moving;
    modport master (output vblnk_in, mouse_left, mouse_xpos, mouse_ypos, input xpos, ypos, moving);
    modport slave (input vblnk_in, mouse_left, mouse_xpos, mouse_ypos, output xpos, ypos, moving);
endinterface

// File: rtl/rect_motion_ctl.sv
// rect_motion_ctl: mouse-placed rectangle that drops under gravity once per frame.
// Define RECT_MOTION_CTL_BOUNCE_EN to bounce at the floor; otherwise every impact comes to rest.
module rect_motion_ctl #(
    parameter int VISIBLE_WIDTH  = 800,
    parameter int VISIBLE_HEIGHT = 600,
    parameter int RECT_WIDTH     = 48,
    parameter int RECT_HEIGHT    = 64,
    parameter int GRAVITY        = 1,
    parameter int VMAX           = 31,
    parameter int BOUNCE_SHIFT   = 1
) (
    input logic             clk,
    input logic             rst,
    rect_motion_ctl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, FALL, RISE, REST} state_t;
    localparam logic [11:0] FLOOR = 12'(VISIBLE_HEIGHT - RECT_HEIGHT);
    localparam logic [11:0] XMAX  = 12'(VISIBLE_WIDTH - RECT_WIDTH);
    localparam logic [6:0]  G     = 7'(GRAVITY);
    localparam logic [6:0]  VLIM  = 7'(VMAX);
`ifdef RECT_MOTION_CTL_BOUNCE_EN
    localparam logic BOUNCE = 1'b1;
`else
    localparam logic BOUNCE = 1'b0;
`endif
    state_t      state;
    logic [5:0]  vel;
    logic        vblnk_q, left_q, armed;
    logic        tick, click;
    logic [11:0] cap_x, cap_y, rise_y;
    logic [6:0]  vsum;
    logic [5:0]  v, bounce_v, rise_v;
    logic [12:0] fall_y;
    // armed stays low for the first cycle after reset so a level held through reset is not an edge
    assign tick     = bus.vblnk_in & ~vblnk_q & armed;
    assign click    = bus.mouse_left & ~left_q & armed;
    assign cap_x    = bus.mouse_xpos > XMAX ? XMAX : bus.mouse_xpos;
    assign cap_y    = bus.mouse_ypos > FLOOR ? FLOOR : bus.mouse_ypos;
    assign vsum     = {1'b0, vel} + G;
    assign v        = vsum > VLIM ? VLIM[5:0] : vsum[5:0];
    assign fall_y   = {1'b0, bus.ypos} + 13'(v);
    assign bounce_v = BOUNCE ? v >> BOUNCE_SHIFT : 6'd0;
    assign rise_y   = bus.ypos > 12'(vel) ? bus.ypos - 12'(vel) : 12'd0;
    assign rise_v   = {1'b0, vel} > G ? vel - G[5:0] : 6'd0;
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            bus.xpos   <= '0;
            bus.ypos   <= '0;
            vel        <= '0;
            bus.moving <= 1'b0;
            vblnk_q    <= 1'b0;
            left_q     <= 1'b0;
            armed      <= 1'b0;
        end else begin
            vblnk_q <= bus.vblnk_in;
            left_q  <= bus.mouse_left;
            armed   <= 1'b1;
            case (state)
                IDLE: begin
                    if (click || tick) begin
                        bus.xpos <= cap_x;
                        bus.ypos <= cap_y;
                    end
                    if (click) begin
                        vel        <= '0;
                        state      <= FALL;
                        bus.moving <= 1'b1;
                    end
                end
                FALL: begin
                    if (tick && fall_y < {1'b0, FLOOR}) begin
                        bus.ypos <= fall_y[11:0];
                        vel      <= v;
                    end else if (tick) begin
                        bus.ypos   <= FLOOR;
                        vel        <= bounce_v;
                        state      <= bounce_v != 0 ? RISE : REST;
                        bus.moving <= bounce_v != 0;
                    end
                end
                RISE: begin
                    if (tick) begin
                        bus.ypos <= rise_y;
                        vel      <= rise_v;
                        state    <= rise_v == 0 ? FALL : RISE;
                    end
                end
                REST: begin
                    if (click) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rect_motion_ctl.sv
// tb_rect_motion_ctl: directed stimulus checked every cycle against a frame-level model of the rectangle.
module tb_rect_motion_ctl;
    localparam int FLOOR = 600 - 64;
    localparam int XMAX  = 800 - 48;
    localparam int GRAV  = 1;
    localparam int VLIM  = 31;
    localparam int BSH   = 1;
`ifdef RECT_MOTION_CTL_BOUNCE_EN
    localparam bit BOUNCE = 1;
`else
    localparam bit BOUNCE = 0;
`endif
    logic clk, rst;
    int checks = 0, errors = 0;
    bit chk_en = 0;
    rect_motion_ctl_if bus();
    rect_motion_ctl dut (.clk(clk), .rst(rst), .bus(bus.slave));

    initial clk = 0;
    always #5 clk = ~clk;

    function automatic int imin(int a, int b); return a < b ? a : b; endfunction
    function automatic int imax(int a, int b); return a > b ? a : b; endfunction

    // model: position/velocity per frame with the phase kept as a name
    int mx = 0, my = 0, mv = 0, since = 0;
    string mst = "IDLE";
    bit pvb = 0, pml = 0;
    always @(posedge clk) begin
        automatic bit tk = bus.vblnk_in && !pvb && since > 0;
        automatic bit ck = bus.mouse_left && !pml && since > 0;
        automatic int nx = mx, ny = my, nv = mv, v = 0, y = 0;
        automatic string ns = mst;
        if (rst) begin
            ns = "IDLE"; nx = 0; ny = 0; nv = 0;
        end else if (mst == "IDLE" && (ck || tk)) begin
            nx = imin(int'(bus.mouse_xpos), XMAX);
            ny = imin(int'(bus.mouse_ypos), FLOOR);
            if (ck) begin nv = 0; ns = "FALL"; end
        end else if (mst == "FALL" && tk) begin
            v = imin(mv + GRAV, VLIM);
            y = my + v;
            if (y < FLOOR) begin ny = y; nv = v; end
            else begin
                ny = FLOOR;
                nv = BOUNCE ? v >> BSH : 0;
                ns = nv > 0 ? "RISE" : "REST";
            end
        end else if (mst == "RISE" && tk) begin
            ny = imax(my - mv, 0);
            nv = imax(mv - GRAV, 0);
            if (nv == 0) ns = "FALL";
        end else if (mst == "REST" && ck) ns = "IDLE";
        mx <= nx; my <= ny; mv <= nv; mst <= ns;
        since <= rst ? 0 : imin(since + 1, 2);
        pvb <= bus.vblnk_in;
        pml <= bus.mouse_left;
    end

    task automatic chk(input string n, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", n, got, exp, $time);
        end
    endtask

    task automatic step();
        @(negedge clk);
        if (chk_en) begin
            chk("model_xpos", int'(bus.xpos), mx);
            chk("model_ypos", int'(bus.ypos), my);
            chk("model_moving", int'(bus.moving), (mst == "FALL" || mst == "RISE") ? 1 : 0);
        end
    endtask

    task automatic pulse(input bit t, input bit c);
        bus.vblnk_in = t; bus.mouse_left = c;
        step();
        bus.vblnk_in = 0; bus.mouse_left = 0;
        step();
    endtask

    task automatic mouse(input int x, input int y);
        bus.mouse_xpos = 12'(x); bus.mouse_ypos = 12'(y);
    endtask

    task automatic lit(input string n, input int x, input int y, input int m);
        chk({"lit_x_", n}, int'(bus.xpos), x);
        chk({"lit_y_", n}, int'(bus.ypos), y);
        chk({"lit_m_", n}, int'(bus.moving), m);
    endtask

    int fall_seq[8] = '{501, 503, 506, 510, 515, 521, 528, 536};
    int rise_seq[4] = '{532, 529, 527, 526};

    initial begin
        rst = 1; bus.vblnk_in = 1; bus.mouse_left = 1; mouse(100, 100);
        step();
        chk_en = 1;
        step();
        lit("reset", 0, 0, 0);
        rst = 0;
        repeat (3) step();
        lit("no_edge_after_reset", 0, 0, 0);
        bus.vblnk_in = 0; bus.mouse_left = 0;
        step();
        mouse(900, 700); pulse(1, 0);
        lit("idle_clamp", 752, 536, 0);
        mouse(100, 200); pulse(1, 0);
        lit("idle_track", 100, 200, 0);
        mouse(300, 500); pulse(0, 1);
        lit("click_capture", 300, 500, 1);
        for (int i = 0; i < 8; i++) begin
            if (i == 3) mouse(999, 10);
            pulse(1, i == 3);
            chk("lit_fall_y", int'(bus.ypos), fall_seq[i]);
        end
        lit("impact", 300, 536, BOUNCE ? 1 : 0);
        if (BOUNCE) begin
            for (int i = 0; i < 4; i++) begin
                pulse(1, 0);
                chk("lit_rise_y", int'(bus.ypos), rise_seq[i]);
            end
            lit("apex", 300, 526, 1);
        end else begin
            pulse(1, 0);
            lit("rest_hold", 300, 536, 0);
        end
        rst = 1; step(); rst = 0; step(); step();
        mouse(10, 520); pulse(0, 1);
        lit("fall_520", 10, 520, 1);
        rst = 1; bus.vblnk_in = 1;
        step();
        lit("abort", 0, 0, 0);
        rst = 0; bus.vblnk_in = 0;
        step(); step();
        mouse(50, 535); pulse(0, 1);
        pulse(1, 0);
        lit("short_drop", 50, 536, 0);
        pulse(1, 0);
        lit("rest_tick", 50, 536, 0);
        mouse(60, 70); pulse(0, 1);
        lit("rest_click", 50, 536, 0);
        pulse(1, 0);
        lit("back_idle", 60, 70, 0);
        mouse(5, 6); pulse(1, 1);
        lit("click_over_tick", 5, 6, 1);
        pulse(1, 0);
        lit("first_fall", 5, 7, 1);
        repeat (5) step();
        lit("hold", 5, 7, 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
